shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 107 ++++++++++
 tb/tb_shift_add_multiplier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: 16x16 unsigned sequential multiplier, one shift-add step per clock.
// Latency: counting the start edge as the first, Q and done update on the 17th rising edge (16 BUSY steps).
// Backpressure: none; start is ignored while busy, and a held start yields one operation.
//
// Ports:
//   clk   - rising-edge clock for all state
//   rst_n - synchronous active-low reset
//   A, B  - unsigned 16-bit operands, latched when an operation starts
//   start - level request, honoured only in IDLE
//   Q     - registered 32-bit product of the last completed operation
//   busy  - high from the load edge through the final iteration
//   done  - one-cycle pulse in the first cycle Q shows a new product
module shift_add_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        start,
   output logic [31:0] Q,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic [3:0]  cnt_q;
   logic [31:0] q_q;
   logic        busy_q;
   logic        done_q;

   // Partial product for this step: A shifted to the weight of the current
   // multiplier bit. The 32-bit accumulator cannot overflow for 16x16 inputs.
   always_comb begin
      acc_d = acc_q;
      if (b_q[0]) begin
         acc_d = acc_q + ({16'd0, a_q} << cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         acc_q   <= 32'd0;
         cnt_q   <= 4'd0;
         q_q     <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  acc_q   <= 32'd0;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               acc_q <= acc_d;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + 4'd1;
               // Counter value 15 marks the 16th step: publish the sum
               // including this step's partial product directly.
               if (cnt_q == 4'd15) begin
                  q_q     <= acc_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               // Wait for start to drop so a held request runs only once.
               if (!start) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Q    = q_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed bench for shift_add_multiplier.
// Drives inputs #1 after each rising edge and samples outputs at the same point.
// Expected products are hand-computed constants.
module tb_shift_add_multiplier;

   logic        clk;
   logic        rst_n;
   logic [15:0] A;
   logic [15:0] B;
   logic        start;
   logic [31:0] Q;
   logic        busy;
   logic        done;

   int total;
   int bad;

   shift_add_multiplier dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .start (start),
      .Q     (Q),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Call right after the edge that sampled start in IDLE. Checks 15 busy
   // cycles with Q held, the result/done on the 16th step, then done dropping.
   task automatic run_op(input logic [31:0] exp_q, input logic [31:0] prev_q, input string tag);
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k < 16) begin
            check({tag, " busy_during_op"}, {31'd0, busy}, 32'd1);
            check({tag, " done_during_op"}, {31'd0, done}, 32'd0);
            check({tag, " q_held"}, Q, prev_q);
         end else begin
            check({tag, " q_result"}, Q, exp_q);
            check({tag, " done_pulse"}, {31'd0, done}, 32'd1);
            check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
         end
      end
      step();
      check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
      check({tag, " q_after"}, Q, exp_q);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      A     = 16'd0;
      B     = 16'd0;

      // Reset state
      step();
      step();
      check("reset_q", Q, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);

      // 1: start held high straight out of reset, then held 20 more cycles
      rst_n = 1'b1;
      start = 1'b1;
      A     = 16'hD472;
      B     = 16'hDE79;
      step();
      run_op(32'd3097445858, 32'd0, "t1");
      for (int k = 0; k < 20; k++) begin
         step();
         check("t1_held_no_busy", {31'd0, busy}, 32'd0);
         check("t1_held_no_done", {31'd0, done}, 32'd0);
         check("t1_held_q", Q, 32'd3097445858);
      end
      start = 1'b0;
      step();

      // 2: start low for two cycles then high; previous Q held during BUSY
      A = 16'h0032;
      B = 16'h067F;
      step();
      check("t2_idle_busy", {31'd0, busy}, 32'd0);
      step();
      check("t2_idle_q", Q, 32'd3097445858);
      start = 1'b1;
      step();
      run_op(32'd83150, 32'd3097445858, "t2");
      start = 1'b0;
      step();

      // 3: operands and start changed during BUSY do not affect the result
      A     = 16'h4032;
      B     = 16'hC67F;
      start = 1'b1;
      step();
      A     = 16'hFFFF;
      B     = 16'hFFFF;
      start = 1'b0;
      run_op(32'd835093710, 32'd83150, "t3");

      // 4: maximum operands, then zero multiplicand with full latency
      A     = 16'hFFFF;
      B     = 16'hFFFF;
      start = 1'b1;
      step();
      start = 1'b0;
      run_op(32'hFFFE0001, 32'd835093710, "t4max");
      A     = 16'h0000;
      B     = 16'h1234;
      start = 1'b1;
      step();
      start = 1'b0;
      run_op(32'd0, 32'hFFFE0001, "t4zero");

      // 5: reset at BUSY cycle 8, then a fresh operation
      A     = 16'h0100;
      B     = 16'h0101;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
      end
      rst_n = 1'b0;
      step();
      check("t5_rst_q", Q, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      step();
      check("t5_idle_after_rst", {31'd0, busy}, 32'd0);
      A     = 16'h1234;
      B     = 16'h0010;
      start = 1'b1;
      step();
      start = 1'b0;
      run_op(32'h00012340, 32'd0, "t5");

      // 6: single-cycle start pulse; count busy cycles and done pulses
      A     = 16'h00FF;
      B     = 16'h0003;
      start = 1'b1;
      step();
      start    = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      if (busy) busy_cnt++;
      for (int k = 0; k < 40; k++) begin
         step();
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      check("t6_busy_cycles", busy_cnt, 32'd16);
      check("t6_done_pulses", done_cnt, 32'd1);
      check("t6_q", Q, 32'd765);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
